// File: rtl/i2c_seq_pkg.sv
// Shared definitions for the I2C command sequencer: FSM state encoding,
// completion status codes and the packed command record width.
// Optional build macro used by the sequencer: I2C_SEQ_RETRY_EN.
package i2c_seq_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_ISSUE      = 3'd1;
    localparam logic [2:0] ST_WAIT_START = 3'd2;
    localparam logic [2:0] ST_WAIT_END   = 3'd3;
    localparam logic [2:0] ST_RESP       = 3'd4;

    typedef enum logic [2:0] {
        IDLE       = ST_IDLE,
        ISSUE      = ST_ISSUE,
        WAIT_START = ST_WAIT_START,
        WAIT_END   = ST_WAIT_END,
        RESP       = ST_RESP
    } seq_state_t;

    localparam logic [3:0] STATUS_OK            = 4'h0;
    localparam logic [3:0] STATUS_START_TIMEOUT = 4'hF;

    localparam int ADDR_BYTES_DEFAULT = 1;
    localparam int DATA_BYTES_DEFAULT = 2;

    // Command record: {rw, chip_addr[6:0], reg_addr, data}
    function automatic int cmd_width(input int addr_bytes, input int data_bytes);
        return 1 + 7 + 8 * addr_bytes + 8 * data_bytes;
    endfunction

    localparam int CMD_W = cmd_width(ADDR_BYTES_DEFAULT, DATA_BYTES_DEFAULT);

    // A NACK-type failure is any nonzero status other than our own start timeout
    function automatic logic is_nack(input logic [3:0] status);
        return (status != STATUS_OK) && (status != STATUS_START_TIMEOUT);
    endfunction

endpackage

// File: rtl/i2c_cmd_sequencer_if.sv
// Command/response bus of the I2C command sequencer. The master modport is
// the system controller side, the slave modport is the sequencer itself.
interface i2c_cmd_sequencer_if
    import i2c_seq_pkg::*;
#(
    parameter int ADDR_BYTES = ADDR_BYTES_DEFAULT,
    parameter int DATA_BYTES = DATA_BYTES_DEFAULT
);

    logic                    cmd_valid;
    logic                    cmd_ready;
    logic                    cmd_rw;
    logic [6:0]              cmd_chip_addr;
    logic [8*ADDR_BYTES-1:0] cmd_reg_addr;
    logic [8*DATA_BYTES-1:0] cmd_data;

    logic                    rsp_valid;
    logic                    rsp_rw;
    logic [8*DATA_BYTES-1:0] rsp_data;
    logic [3:0]              rsp_status;
    logic                    rsp_err;

    modport master (
        output cmd_valid, cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data,
        input  cmd_ready,
        input  rsp_valid, rsp_rw, rsp_data, rsp_status, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_chip_addr, cmd_reg_addr, cmd_data,
        output cmd_ready,
        output rsp_valid, rsp_rw, rsp_data, rsp_status, rsp_err
    );

endinterface

// File: rtl/i2c_seq_fifo.sv
// Synchronous command FIFO for the I2C sequencer. Full, empty and level are
// registered so they can drive handshake outputs directly. Pushes while full
// and pops while empty are ignored.
module i2c_seq_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    level_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged
    always_comb begin
        level_next = level;
        case ({do_push, do_pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            level <= level_next;
            full  <= (level_next == DEPTH_L);
            empty <= (level_next == '0);
        end
    end

    // Storage array needs no reset; only occupied entries are ever read
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/i2c_cmd_sequencer.sv
// Command-queue front end for i2c_master: buffers commands in a FIFO, issues
// them one at a time on the write_en/read_en strobes, waits for completion and
// returns one response per command.
// Optional build macro: I2C_SEQ_RETRY_EN reissues NACKed commands up to two
// more times before responding.
module i2c_cmd_sequencer
    import i2c_seq_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 2,
    parameter int START_WAIT = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    i2c_cmd_sequencer_if.slave        bus,
    output logic [$clog2(DEPTH):0]    level,
    output logic                      idle,
    output logic [6:0]                m_chip_addr,
    output logic [8*ADDR_BYTES-1:0]   m_reg_addr,
    output logic [8*DATA_BYTES-1:0]   m_data_in,
    output logic                      m_write_en,
    output logic                      m_read_en,
    input  logic                      m_busy,
    input  logic                      m_done,
    input  logic [3:0]                m_status,
    input  logic [8*DATA_BYTES-1:0]   m_data_out
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam int CW = cmd_width(ADDR_BYTES, DATA_BYTES);
    localparam int TW = $clog2(START_WAIT + 1);

    seq_state_t      state;
    seq_state_t      state_next;

    logic [CW-1:0]   fifo_wr_data;
    logic [CW-1:0]   fifo_rd_data;
    logic            fifo_full;
    logic            fifo_empty;
    logic            fifo_push;
    logic            pop;

    logic            head_rw;
    logic [6:0]      head_chip;
    logic [AW-1:0]   head_reg;
    logic [DW-1:0]   head_data;

    logic            hold_rw;
    logic [6:0]      hold_chip;
    logic [AW-1:0]   hold_reg;
    logic [DW-1:0]   hold_data;

    logic [TW-1:0]   timer;
    logic            finish;
    logic            timed_out;

    logic            rsp_rw_q;
    logic [DW-1:0]   rsp_data_q;
    logic [3:0]      rsp_status_q;
    logic            rsp_err_q;

`ifdef I2C_SEQ_RETRY_EN
    logic [1:0]      retry_cnt;
    logic            reissue;
`endif

    assign fifo_wr_data = {bus.cmd_rw, bus.cmd_chip_addr, bus.cmd_reg_addr, bus.cmd_data};
    assign fifo_push    = bus.cmd_valid && bus.cmd_ready;
    assign {head_rw, head_chip, head_reg, head_data} = fifo_rd_data;

    i2c_seq_fifo #(
        .WIDTH (CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (fifo_push),
        .pop     (pop),
        .wr_data (fifo_wr_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (level)
    );

    assign bus.cmd_ready  = !fifo_full;
    assign bus.rsp_rw     = rsp_rw_q;
    assign bus.rsp_data   = rsp_data_q;
    assign bus.rsp_status = rsp_status_q;
    assign bus.rsp_err    = rsp_err_q;

    assign m_chip_addr = hold_chip;
    assign m_reg_addr  = hold_reg;
    assign m_data_in   = hold_data;

    // State register; reset aborts any transaction without a response
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic and strobe/response/idle outputs decoded from the state
    always_comb begin
        state_next    = state;
        pop           = 1'b0;
        finish        = 1'b0;
        timed_out     = 1'b0;
        m_write_en    = 1'b0;
        m_read_en     = 1'b0;
        bus.rsp_valid = 1'b0;
        idle          = 1'b0;
`ifdef I2C_SEQ_RETRY_EN
        reissue       = 1'b0;
`endif
        case (state)
            IDLE: begin
                idle = fifo_empty;
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                m_write_en = !hold_rw;
                m_read_en  = hold_rw;
                state_next = WAIT_START;
            end
            WAIT_START: begin
                if (m_busy) begin
                    state_next = WAIT_END;
                end else if (timer == TW'(START_WAIT - 1)) begin
                    timed_out  = 1'b1;
                    state_next = RESP;
                end
            end
            WAIT_END: begin
                if (!m_busy || m_done) begin
                    finish     = 1'b1;
                    state_next = RESP;
`ifdef I2C_SEQ_RETRY_EN
                    if (is_nack(m_status) && (retry_cnt != 2'd2)) begin
                        reissue    = 1'b1;
                        state_next = ISSUE;
                    end
`endif
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                state_next    = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Holding registers keep the master-side fields stable until RESP exits
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_rw   <= 1'b0;
            hold_chip <= '0;
            hold_reg  <= '0;
            hold_data <= '0;
        end else if (pop) begin
            hold_rw   <= head_rw;
            hold_chip <= head_chip;
            hold_reg  <= head_reg;
            hold_data <= head_data;
        end
    end

    // Timer counts cycles since the strobe while waiting for busy to rise
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer <= '0;
        end else if (state == ISSUE) begin
            timer <= TW'(1);
        end else if (state == WAIT_START) begin
            timer <= timer + TW'(1);
        end
    end

    // Response capture; every attempt overwrites so the final one is reported
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rw_q     <= 1'b0;
            rsp_data_q   <= '0;
            rsp_status_q <= STATUS_OK;
            rsp_err_q    <= 1'b0;
        end else if (timed_out) begin
            rsp_rw_q     <= hold_rw;
            rsp_data_q   <= '0;
            rsp_status_q <= STATUS_START_TIMEOUT;
            rsp_err_q    <= 1'b1;
        end else if (finish) begin
            rsp_rw_q     <= hold_rw;
            rsp_data_q   <= hold_rw ? m_data_out : '0;
            rsp_status_q <= m_status;
            rsp_err_q    <= (m_status != STATUS_OK);
        end
    end

`ifdef I2C_SEQ_RETRY_EN
    // Retry counter restarts with every command taken from the FIFO
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt <= 2'd0;
        end else if (pop) begin
            retry_cnt <= 2'd0;
        end else if (reissue) begin
            retry_cnt <= retry_cnt + 2'd1;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_cmd_sequencer.sv
// Directed bench for i2c_cmd_sequencer with a behavioural i2c_master/slave
// model (chip 7'h0F answers, any other chip NACKs with status 4'h2).
// Honours I2C_SEQ_RETRY_EN for the expected strobe count on NACK.
module tb_i2c_cmd_sequencer;

    localparam int NACK_STROBES =
`ifdef I2C_SEQ_RETRY_EN
        3;
`else
        1;
`endif

    logic        clk;
    logic        rst;
    logic [3:0]  level;
    logic        idle;
    logic [6:0]  m_chip_addr;
    logic [7:0]  m_reg_addr;
    logic [15:0] m_data_in;
    logic        m_write_en;
    logic        m_read_en;
    logic        m_busy;
    logic        m_done;
    logic [3:0]  m_status;
    logic [15:0] m_data_out;

    i2c_cmd_sequencer_if #(.ADDR_BYTES(1), .DATA_BYTES(2)) bus ();

    i2c_cmd_sequencer #(
        .DEPTH(8), .ADDR_BYTES(1), .DATA_BYTES(2), .START_WAIT(16)
    ) dut (
        .clk         (clk),
        .reset       (rst),
        .bus         (bus),
        .level       (level),
        .idle        (idle),
        .m_chip_addr (m_chip_addr),
        .m_reg_addr  (m_reg_addr),
        .m_data_in   (m_data_in),
        .m_write_en  (m_write_en),
        .m_read_en   (m_read_en),
        .m_busy      (m_busy),
        .m_done      (m_done),
        .m_status    (m_status),
        .m_data_out  (m_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    // Master/slave model: busy rises 2 cycles after a strobe, lasts 6 cycles
    logic [15:0] slave_regs [256];
    logic        no_start;
    logic        stall;
    int          strobe_count;
    int          strobe_cyc;
    int          start_cnt;
    int          busy_cnt;
    bit          starting;
    logic        t_rw;
    logic [6:0]  t_chip;
    logic [7:0]  t_reg;
    logic [15:0] t_data;

    always @(negedge clk) begin
        if (rst) begin
            m_busy = 1'b0; m_done = 1'b0; m_status = 4'h0; m_data_out = 16'h0;
            starting = 0; start_cnt = 0; busy_cnt = 0;
            if (cyc < 5) begin
                strobe_count = 0; strobe_cyc = 0;
                for (int i = 0; i < 256; i++) slave_regs[i] = 16'h0;
            end
        end else begin
            m_done = 1'b0;
            if (m_write_en || m_read_en) begin
                strobe_count++;
                strobe_cyc = cyc;
                if (!no_start) begin
                    t_rw = m_read_en; t_chip = m_chip_addr; t_reg = m_reg_addr; t_data = m_data_in;
                    starting = 1; start_cnt = 2;
                end
            end else if (starting) begin
                start_cnt--;
                if (start_cnt == 0) begin starting = 0; m_busy = 1'b1; busy_cnt = 6; end
            end else if (m_busy && !stall) begin
                busy_cnt--;
                if (busy_cnt == 0) begin
                    m_busy = 1'b0; m_done = 1'b1;
                    if (t_chip == 7'h0F) begin
                        m_status = 4'h0;
                        if (t_rw) m_data_out = slave_regs[t_reg];
                        else      slave_regs[t_reg] = t_data;
                    end else begin
                        m_status = 4'h2;
                    end
                end
            end
        end
    end

    // Response monitor
    typedef struct { logic rw; logic [15:0] data; logic [3:0] status; logic err; } rsp_t;
    rsp_t rsp_q [$];
    int   rsp_count = 0;
    int   rsp_cyc   = 0;

    always @(negedge clk) begin
        if (!rst && bus.rsp_valid) begin
            rsp_q.push_back('{bus.rsp_rw, bus.rsp_data, bus.rsp_status, bus.rsp_err});
            rsp_count++;
            rsp_cyc = cyc;
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic rw, input logic [6:0] chip, input logic [7:0] ra, input logic [15:0] data);
        bus.cmd_valid     = 1'b1;
        bus.cmd_rw        = rw;
        bus.cmd_chip_addr = chip;
        bus.cmd_reg_addr  = ra;
        bus.cmd_data      = data;
        @(negedge clk);
        bus.cmd_valid     = 1'b0;
    endtask

    task automatic wait_rsp(input string name, input int target, input int budget);
        int n = 0;
        while (rsp_count < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_output({name, "_rsp_arrived"}, 32'(rsp_count >= target), 32'd1);
    endtask

    typedef struct {
        string       name;
        logic        rw;
        logic [6:0]  chip;
        logic [7:0]  reg_addr;
        logic [15:0] data;
        logic        exp_rw;
        logic [15:0] exp_data;
        logic [3:0]  exp_status;
        logic        exp_err;
        int          exp_strobes;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int   base_rsp;
        int   base_strobe;
        int   errs;
        rsp_t r;
        logic [7:0]  w_reg  [4];
        logic [15:0] w_data [4];

        vecs[0] = '{"wr_0a",     1'b0, 7'h0F, 8'h0A, 16'hB2B2, 1'b0, 16'h0000, 4'h0, 1'b0, 1};
        vecs[1] = '{"rd_0a",     1'b1, 7'h0F, 8'h0A, 16'h0000, 1'b1, 16'hB2B2, 4'h0, 1'b0, 1};
        vecs[2] = '{"wr_nack",   1'b0, 7'h22, 8'h05, 16'h1234, 1'b0, 16'h0000, 4'h2, 1'b1, NACK_STROBES};
        vecs[3] = '{"rd_00",     1'b1, 7'h0F, 8'h00, 16'h0000, 1'b1, 16'hA1A1, 4'h0, 1'b0, 1};
        vecs[4] = '{"wr_ff",     1'b0, 7'h0F, 8'hFF, 16'h0001, 1'b0, 16'h0000, 4'h0, 1'b0, 1};
        vecs[5] = '{"rd_ff",     1'b1, 7'h0F, 8'hFF, 16'hFFFF, 1'b1, 16'h0001, 4'h0, 1'b0, 1};
        w_reg[0] = 8'h00; w_reg[1] = 8'h0A; w_reg[2] = 8'h10; w_reg[3] = 8'h1A;
        w_data[0] = 16'hA1A1; w_data[1] = 16'hB2B2; w_data[2] = 16'hC3C3; w_data[3] = 16'hD4D4;

        rst = 1'b1; no_start = 1'b0; stall = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_rw = 1'b0; bus.cmd_chip_addr = '0;
        bus.cmd_reg_addr = '0; bus.cmd_data = '0;
        repeat (3) @(negedge clk);

        check_output("reset_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("reset_idle",      32'(idle), 32'd1);
        check_output("reset_level",     32'(level), 32'd0);
        check_output("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check_output("reset_strobes",   32'({m_write_en, m_read_en}), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] four back-to-back writes");
        base_rsp = rsp_count;
        for (int i = 0; i < 4; i++) apply_stimulus(1'b0, 7'h0F, w_reg[i], w_data[i]);
        wait_rsp("four_writes", base_rsp + 4, 400);
        errs = 0;
        for (int i = base_rsp; i < rsp_q.size(); i++) errs += int'(rsp_q[i].err);
        check_output("four_writes_errs", 32'(errs), 32'd0);
        for (int i = 0; i < 4; i++) check_output($sformatf("slave_reg_%0h", w_reg[i]), 32'(slave_regs[w_reg[i]]), 32'(w_data[i]));

        $display("[TB] table vectors");
        for (int i = 0; i < 6; i++) begin
            base_rsp    = rsp_count;
            base_strobe = strobe_count;
            apply_stimulus(vecs[i].rw, vecs[i].chip, vecs[i].reg_addr, vecs[i].data);
            wait_rsp(vecs[i].name, base_rsp + 1, 300);
            repeat (2) @(negedge clk);
            if (rsp_count > base_rsp) begin
                r = rsp_q[base_rsp];
                check_output({vecs[i].name, "_rw"},     32'(r.rw),     32'(vecs[i].exp_rw));
                check_output({vecs[i].name, "_data"},   32'(r.data),   32'(vecs[i].exp_data));
                check_output({vecs[i].name, "_status"}, 32'(r.status), 32'(vecs[i].exp_status));
                check_output({vecs[i].name, "_err"},    32'(r.err),    32'(vecs[i].exp_err));
            end
            check_output({vecs[i].name, "_strobes"}, 32'(strobe_count - base_strobe), 32'(vecs[i].exp_strobes));
            check_output({vecs[i].name, "_one_rsp"}, 32'(rsp_count - base_rsp), 32'd1);
        end

        $display("[TB] full FIFO with master stalled");
        stall = 1'b1;
        base_rsp = rsp_count;
        for (int i = 0; i < 9; i++) apply_stimulus(1'b0, 7'h0F, 8'h40 + 8'(i), 16'h5000 + 16'(i));
        check_output("full_level",     32'(level), 32'd8);
        check_output("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check_output("full_idle",      32'(idle), 32'd0);
        check_output("held_data_in",   32'(m_data_in), 32'h5000);
        check_output("held_reg_addr",  32'(m_reg_addr), 32'h40);
        apply_stimulus(1'b0, 7'h0F, 8'h4A, 16'hDEAD);
        check_output("full_level_after_extra", 32'(level), 32'd8);
        stall = 1'b0;
        wait_rsp("full_drain", base_rsp + 9, 400);
        repeat (50) @(negedge clk);
        check_output("full_rsp_count", 32'(rsp_count - base_rsp), 32'd9);
        check_output("full_last_reg",  32'(slave_regs[8'h48]), 32'h5008);
        check_output("full_extra_dropped", 32'(slave_regs[8'h4A]), 32'h0);
        check_output("drained_idle",   32'(idle), 32'd1);

        $display("[TB] start timeout");
        no_start = 1'b1;
        base_rsp = rsp_count;
        apply_stimulus(1'b0, 7'h0F, 8'h50, 16'h7777);
        wait_rsp("timeout", base_rsp + 1, 100);
        if (rsp_count > base_rsp) begin
            r = rsp_q[base_rsp];
            check_output("timeout_latency", 32'(rsp_cyc - strobe_cyc), 32'd16);
            check_output("timeout_status",  32'(r.status), 32'hF);
            check_output("timeout_err",     32'(r.err), 32'd1);
        end
        no_start = 1'b0;
        repeat (3) @(negedge clk);

        $display("[TB] reset mid-transaction");
        stall = 1'b1;
        base_rsp = rsp_count;
        apply_stimulus(1'b0, 7'h0F, 8'h30, 16'h1111);
        apply_stimulus(1'b0, 7'h0F, 8'h31, 16'h2222);
        begin
            int n = 0;
            while (!m_busy && n < 50) begin @(negedge clk); n++; end
            check_output("busy_seen_before_reset", 32'(m_busy), 32'd1);
        end
        repeat (3) @(negedge clk);
        check_output("pre_reset_level", 32'(level), 32'd1);
        #2 rst = 1'b1;
        #1;
        check_output("async_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check_output("async_idle",      32'(idle), 32'd1);
        check_output("async_level",     32'(level), 32'd0);
        check_output("async_chip_addr", 32'(m_chip_addr), 32'd0);
        check_output("async_strobes",   32'({m_write_en, m_read_en, bus.rsp_valid}), 32'd0);
        stall = 1'b0;
        repeat (2) @(negedge clk);
        base_strobe = strobe_count;
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check_output("post_reset_no_rsp",     32'(rsp_count - base_rsp), 32'd0);
        check_output("post_reset_no_strobe",  32'(strobe_count - base_strobe), 32'd0);
        check_output("post_reset_idle",       32'(idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
